// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// The FAIL state is only reachable when PLLSEQ_FAIL_LIMIT_EN is defined.
package pll_seq_pkg;

    localparam int unsigned SatW = 8;

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StStable,
        StRelease,
        StRun,
        StFail
    } pll_state_e;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic logic [SatW-1:0] sat_inc(input logic [SatW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-high reset.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_sequencer.sv
// Brings the PLL out of reset, waits for stable lock, then releases domain resets in order.
// Define PLLSEQ_FAIL_LIMIT_EN to stop in a sticky FAIL state after MAX_RETRY lock timeouts.
module pll_rst_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS        = 4,
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 20000,
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned RELEASE_GAP        = 8,
    parameter int unsigned MAX_RETRY          = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_lock,
    input  logic                   soft_req,
    output logic                   pll_reset,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   ready,
    output logic [SatW-1:0]        retry_cnt,
    output logic [SatW-1:0]        lost_cnt,
    output logic                   fail
);

    localparam int unsigned ReleaseSpan = RELEASE_GAP * (NUM_DOMAINS - 1);
    localparam int unsigned CntW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES,
                                             ReleaseSpan + 1);
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t RstLast     = cnt_t'(PLL_RST_CYCLES - 1);
    localparam cnt_t TimeoutLast = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t StableLast  = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t ReleaseLast = cnt_t'(ReleaseSpan);

    logic lock_s;

    sync_2ff #(
        .Width(1)
    ) u_lock_sync (
        .clk(clk),
        .rst(rst),
        .d_i(pll_lock),
        .q_o(lock_s)
    );

    pll_state_e             state_q, state_d;
    cnt_t                   cnt_q, cnt_d;
    logic                   pll_reset_q, pll_reset_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                   ready_q, ready_d;
    logic [SatW-1:0]        retry_q, retry_d;
    logic [SatW-1:0]        lost_q, lost_d;
`ifdef PLLSEQ_FAIL_LIMIT_EN
    logic                   fail_q, fail_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pll_reset_d = pll_reset_q;
        dom_rst_d   = dom_rst_q;
        ready_d     = ready_q;
        retry_d     = retry_q;
        lost_d      = lost_q;
`ifdef PLLSEQ_FAIL_LIMIT_EN
        fail_d      = fail_q;
`endif
        unique case (state_q)
            StPllRst: begin
                if (cnt_q == RstLast) begin
                    state_d     = StWaitLock;
                    cnt_d       = '0;
                    pll_reset_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d       = '0;
                    pll_reset_d = 1'b1;
                    retry_d     = sat_inc(retry_q);
`ifdef PLLSEQ_FAIL_LIMIT_EN
                    if (32'(retry_d) >= MAX_RETRY) begin
                        state_d = StFail;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = StPllRst;
                    end
`else
                    state_d = StPllRst;
`endif
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StStable: begin
                // Any dropout restarts the full timeout window, not just the stable count.
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d      = StRelease;
                    cnt_d        = '0;
                    dom_rst_d[0] = 1'b0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StRelease, StRun: begin
                if (!lock_s || soft_req) begin
                    state_d     = StPllRst;
                    cnt_d       = '0;
                    pll_reset_d = 1'b1;
                    dom_rst_d   = '1;
                    ready_d     = 1'b0;
                    if (!lock_s) lost_d = sat_inc(lost_q);
                end else if (state_q == StRelease) begin
                    if (cnt_q == ReleaseLast) begin
                        state_d = StRun;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                        for (int unsigned i = 1; i < NUM_DOMAINS; i++) begin
                            if (32'(cnt_d) >= RELEASE_GAP * i) dom_rst_d[i] = 1'b0;
                        end
                    end
                end
            end
`ifdef PLLSEQ_FAIL_LIMIT_EN
            StFail: begin
                pll_reset_d = 1'b1;
                dom_rst_d   = '1;
                ready_d     = 1'b0;
                fail_d      = 1'b1;
            end
`endif
            default: begin
                state_d     = StPllRst;
                cnt_d       = '0;
                pll_reset_d = 1'b1;
                dom_rst_d   = '1;
                ready_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StPllRst;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            dom_rst_q   <= '1;
            ready_q     <= 1'b0;
            retry_q     <= '0;
            lost_q      <= '0;
`ifdef PLLSEQ_FAIL_LIMIT_EN
            fail_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_reset_q <= pll_reset_d;
            dom_rst_q   <= dom_rst_d;
            ready_q     <= ready_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
`ifdef PLLSEQ_FAIL_LIMIT_EN
            fail_q      <= fail_d;
`endif
        end
    end

    assign pll_reset = pll_reset_q;
    assign dom_rst   = dom_rst_q;
    assign ready     = ready_q;
    assign retry_cnt = retry_q;
    assign lost_cnt  = lost_q;
`ifdef PLLSEQ_FAIL_LIMIT_EN
    assign fail      = fail_q;
`else
    assign fail      = 1'b0;
`endif

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Directed bench for pll_rst_sequencer; cycle k is the sample taken after the k-th clk edge
// following rst release.
module tb_pll_rst_sequencer;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         pll_lock;
    logic         soft_req;
    logic         pll_reset;
    logic [N-1:0] dom_rst;
    logic         ready;
    logic [7:0]   retry_cnt;
    logic [7:0]   lost_cnt;
    logic         fail;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    pll_rst_sequencer #(
        .NUM_DOMAINS(N),
        .PLL_RST_CYCLES(16),
        .LOCK_TIMEOUT(20000),
        .LOCK_STABLE_CYCLES(256),
        .RELEASE_GAP(8),
        .MAX_RETRY(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_lock(pll_lock),
        .soft_req(soft_req),
        .pll_reset(pll_reset),
        .dom_rst(dom_rst),
        .ready(ready),
        .retry_cnt(retry_cnt),
        .lost_cnt(lost_cnt),
        .fail(fail)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input logic lock);
        rst      = 1'b1;
        pll_lock = lock;
        soft_req = 1'b0;
        run(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] got;
        rst      = 1'b1;
        pll_lock = 1'b0;
        soft_req = 1'b0;
        repeat (5) @(negedge clk);
        got = {pll_reset, dom_rst, ready, retry_cnt, lost_cnt, fail};
        n_checks++;
        if (got !== {1'b1, 4'hF, 1'b0, 8'd0, 8'd0, 1'b0})
            $display("FAIL reset_values: got %h want %h", got,
                     {1'b1, 4'hF, 1'b0, 8'd0, 8'd0, 1'b0});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_power_up();
        logic [N+1:0] got;
        logic [N+1:0] exp;
        for (int k = 0; k <= 324; k++) begin
            if (k == 40) pll_lock = 1'b1;
            tick();
            exp[N+1] = (k < 15);
            for (int i = 0; i < N; i++) exp[1+i] = (k < 298 + 8 * i);
            exp[0] = (k >= 323);
            got = {pll_reset, dom_rst, ready};
            n_checks++;
            if (got !== exp)
                $display("FAIL power_up cycle %0d {pll_reset,dom_rst,ready}: got %b want %b",
                         k, got, exp);
            else n_pass++;
        end
        n_checks++;
        if ({retry_cnt, lost_cnt} !== 16'h0000)
            $display("FAIL power_up_counters: got %h want 0000", {retry_cnt, lost_cnt});
        else n_pass++;
    endtask

    task automatic test_lock_loss_run();
        pll_lock = 1'b0;
        run(2);
        n_checks++;
        if (ready !== 1'b1) $display("FAIL loss_sync_latency ready: got %b want 1", ready);
        else n_pass++;
        tick();
        n_checks++;
        if ({pll_reset, dom_rst, ready} !== {1'b1, 4'hF, 1'b0})
            $display("FAIL loss_outputs: got %b want %b", {pll_reset, dom_rst, ready},
                     {1'b1, 4'hF, 1'b0});
        else n_pass++;
        n_checks++;
        if ({retry_cnt, lost_cnt} !== {8'd0, 8'd1})
            $display("FAIL loss_counters: got %h want 0001", {retry_cnt, lost_cnt});
        else n_pass++;
        pll_lock = 1'b1;
        run(15);
        n_checks++;
        if (pll_reset !== 1'b1) $display("FAIL loss_pll_reset_last_high: got %b want 1", pll_reset);
        else n_pass++;
        tick();
        n_checks++;
        if (pll_reset !== 1'b0) $display("FAIL loss_pll_reset_fall: got %b want 0", pll_reset);
        else n_pass++;
        run(256);
        n_checks++;
        if (dom_rst !== 4'hF) $display("FAIL loss_pre_release: got %h want F", dom_rst);
        else n_pass++;
        tick();
        n_checks++;
        if (dom_rst !== 4'hE) $display("FAIL loss_release0: got %h want E", dom_rst);
        else n_pass++;
        run(24);
        n_checks++;
        if ({dom_rst, ready} !== 5'b0000_0)
            $display("FAIL loss_release3: got %b want 00000", {dom_rst, ready});
        else n_pass++;
        tick();
        n_checks++;
        if (ready !== 1'b1) $display("FAIL loss_ready_again: got %b want 1", ready);
        else n_pass++;
    endtask

    task automatic test_soft_req();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        n_checks++;
        if ({pll_reset, dom_rst, ready, lost_cnt, retry_cnt} !== {1'b1, 4'hF, 1'b0, 8'd1, 8'd0})
            $display("FAIL soft_req_run: got %h want %h",
                     {pll_reset, dom_rst, ready, lost_cnt, retry_cnt},
                     {1'b1, 4'hF, 1'b0, 8'd1, 8'd0});
        else n_pass++;
        run(3);
        soft_req = 1'b1;  // ignored in PLL_RST
        tick();
        soft_req = 1'b0;
        run(12);
        n_checks++;
        if (pll_reset !== 1'b0) $display("FAIL soft_req_ignored_pll_rst: got %b want 0", pll_reset);
        else n_pass++;
        run(82);
        soft_req = 1'b1;  // ignored in STABLE
        tick();
        soft_req = 1'b0;
        run(173);
        n_checks++;
        if (dom_rst !== 4'hF) $display("FAIL soft_pre_release: got %h want F", dom_rst);
        else n_pass++;
        tick();
        n_checks++;
        if (dom_rst !== 4'hE) $display("FAIL soft_ignored_stable_release0: got %h want E", dom_rst);
        else n_pass++;
        run(24);
        n_checks++;
        if (ready !== 1'b0) $display("FAIL soft_ready_early: got %b want 0", ready);
        else n_pass++;
        tick();
        n_checks++;
        if ({ready, lost_cnt, retry_cnt} !== {1'b1, 8'd1, 8'd0})
            $display("FAIL soft_ready_again: got %h want %h", {ready, lost_cnt, retry_cnt},
                     {1'b1, 8'd1, 8'd0});
        else n_pass++;
    endtask

    task automatic test_soft_and_loss();
        pll_lock = 1'b0;
        run(2);
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        n_checks++;
        if ({dom_rst, ready, lost_cnt} !== {4'hF, 1'b0, 8'd2})
            $display("FAIL soft_and_loss: got %h want %h", {dom_rst, ready, lost_cnt},
                     {4'hF, 1'b0, 8'd2});
        else n_pass++;
    endtask

    task automatic test_async_rst_release();
        logic [22:0] got;
        pll_lock = 1'b1;
        run(283);
        n_checks++;
        if (dom_rst !== 4'b1100) $display("FAIL mid_release_dom: got %b want 1100", dom_rst);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        got = {pll_reset, dom_rst, ready, retry_cnt, lost_cnt, fail};
        n_checks++;
        if (got !== {1'b1, 4'hF, 1'b0, 8'd0, 8'd0, 1'b0})
            $display("FAIL async_rst_values: got %h want %h", got,
                     {1'b1, 4'hF, 1'b0, 8'd0, 8'd0, 1'b0});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stable_glitch();
        do_reset(1'b0);
        for (int k = 0; k <= 424; k++) begin
            if (k == 40) pll_lock = 1'b1;
            if (k == 140) pll_lock = 1'b0;
            if (k == 141) pll_lock = 1'b1;
            tick();
            if (k == 298 || k == 398) begin
                n_checks++;
                if (dom_rst !== 4'hF)
                    $display("FAIL glitch_hold cycle %0d: got %h want F", k, dom_rst);
                else n_pass++;
            end
            if (k == 399) begin
                n_checks++;
                if (dom_rst !== 4'hE) $display("FAIL glitch_release0: got %h want E", dom_rst);
                else n_pass++;
            end
            if (k == 423 || k == 424) begin
                n_checks++;
                if (ready !== (k == 424))
                    $display("FAIL glitch_ready cycle %0d: got %b want %b", k, ready, k == 424);
                else n_pass++;
            end
        end
        n_checks++;
        if ({retry_cnt, lost_cnt} !== 16'h0000)
            $display("FAIL glitch_counters: got %h want 0000", {retry_cnt, lost_cnt});
        else n_pass++;
    endtask

    task automatic test_lock_timeout();
        do_reset(1'b0);
        run(20015);
        n_checks++;
        if ({pll_reset, retry_cnt} !== {1'b0, 8'd0})
            $display("FAIL timeout_before: got %h want %h", {pll_reset, retry_cnt}, {1'b0, 8'd0});
        else n_pass++;
        tick();
        n_checks++;
        if ({pll_reset, retry_cnt} !== {1'b1, 8'd1})
            $display("FAIL timeout_first: got %h want %h", {pll_reset, retry_cnt}, {1'b1, 8'd1});
        else n_pass++;
        run(15);
        n_checks++;
        if (pll_reset !== 1'b1) $display("FAIL timeout_pulse_hold: got %b want 1", pll_reset);
        else n_pass++;
        tick();
        n_checks++;
        if (pll_reset !== 1'b0) $display("FAIL timeout_pulse_end: got %b want 0", pll_reset);
        else n_pass++;
        run(40015);
        n_checks++;
        if ({pll_reset, retry_cnt} !== {1'b0, 8'd2})
            $display("FAIL timeout_before_third: got %h want %h", {pll_reset, retry_cnt},
                     {1'b0, 8'd2});
        else n_pass++;
        tick();
        n_checks++;
        if ({pll_reset, retry_cnt, dom_rst, ready, fail} !== {1'b1, 8'd3, 4'hF, 1'b0, 1'b0})
            $display("FAIL timeout_third: got %h want %h",
                     {pll_reset, retry_cnt, dom_rst, ready, fail},
                     {1'b1, 8'd3, 4'hF, 1'b0, 1'b0});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss_run();
        test_soft_req();
        test_soft_and_loss();
        test_async_rst_release();
        test_stable_glitch();
        test_lock_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
